ex_wb_buffer: RTL and testbench

Two-entry elastic pipeline buffer directly downstream of the combinational ALU in the execute stage. It captures the ALU result with its destination register, holds it under writeback backpressure without dropping or duplicating results, and drives the register-file write port. Two combinational lookup ports let decode forward in-flight results to rs1/rs2 before writeback.

---
 rtl/ex_wb_buffer_pkg.sv | 34 +++
 rtl/ex_wb_fwd.sv | 28 ++
 rtl/ex_wb_buffer.sv | 101 ++++++++++
 tb/tb_ex_wb_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ex_wb_buffer_pkg.sv
// Shared types and helpers for the execute-to-writeback result buffer.
// Entry widths are fixed here; the buffer's XLEN/RADDR parameters must match them.
package ex_wb_buffer_pkg;

  localparam int WB_XLEN  = 32;
  localparam int WB_RADDR = 5;

  typedef struct packed {
    logic                valid;
    logic                wren;
    logic [WB_RADDR-1:0] waddr;
    logic [WB_XLEN-1:0]  wdata;
  } wb_entry_type;

  typedef struct packed {
    logic                valid;
    logic                wren;
    logic [WB_RADDR-1:0] waddr;
    logic [WB_XLEN-1:0]  wdata;
  } ex_wb_in_type;

  typedef struct packed {
    logic                valid;
    logic                wren;
    logic [WB_RADDR-1:0] waddr;
    logic [WB_XLEN-1:0]  wdata;
  } ex_wb_out_type;

  // x0 is hardwired to zero, so it must never be forwarded.
  function automatic logic fwd_match(input wb_entry_type entry, input logic [WB_RADDR-1:0] raddr);
    return entry.valid && entry.wren && (entry.waddr == raddr) && (raddr != '0);
  endfunction

endpackage

// File: rtl/ex_wb_fwd.sv
// One forwarding lookup over the two buffered entries.
// The skid entry is younger, so it wins when both entries match.
module ex_wb_fwd
  import ex_wb_buffer_pkg::*;
(
  input  wb_entry_type        head,
  input  wb_entry_type        skid,
  input  logic [WB_RADDR-1:0] raddr,
  output logic                hit,
  output logic [WB_XLEN-1:0]  data
);

  logic hit_head;
  logic hit_skid;

  always_comb begin
    hit_head = fwd_match(head, raddr);
    hit_skid = fwd_match(skid, raddr);
    hit      = hit_head || hit_skid;
    data     = '0;
    if (hit_skid) begin
      data = skid.wdata;
    end else if (hit_head) begin
      data = head.wdata;
    end
  end

endmodule

// File: rtl/ex_wb_buffer.sv
// Two-entry elastic buffer between the ALU and the register-file write port,
// with two combinational forwarding lookups for decode.
module ex_wb_buffer
  import ex_wb_buffer_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int RADDR = WB_RADDR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wren,
  input  logic [RADDR-1:0] in_waddr,
  input  logic [XLEN-1:0]  in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wren,
  output logic [RADDR-1:0] out_waddr,
  output logic [XLEN-1:0]  out_wdata,
  input  logic [RADDR-1:0] fwd_raddr1,
  input  logic [RADDR-1:0] fwd_raddr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [XLEN-1:0]  fwd_data1,
  output logic [XLEN-1:0]  fwd_data2
);

  wb_entry_type  head_q, skid_q;
  wb_entry_type  head_d, skid_d;
  wb_entry_type  new_entry;
  ex_wb_in_type  in_pkt;
  ex_wb_out_type out_pkt;
  logic          accept;
  logic          drain;

  assign in_pkt = '{valid: in_valid, wren: in_wren, waddr: in_waddr, wdata: in_wdata};

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready = !skid_q.valid;
  assign accept   = in_pkt.valid && in_ready;
  assign drain    = head_q.valid && out_ready;

  always_comb begin
    new_entry = '{valid: 1'b1, wren: in_pkt.wren, waddr: in_pkt.waddr, wdata: in_pkt.wdata};
    head_d    = head_q;
    skid_d    = skid_q;
    if (drain) begin
      head_d       = skid_q;
      skid_d.valid = 1'b0;
    end
    if (accept) begin
      if (!head_d.valid) begin
        head_d = new_entry;
      end else begin
        skid_d = new_entry;
      end
    end
  end

  // Only the valid bits are cleared; payload fields are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      head_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    out_pkt.valid = head_q.valid;
    out_pkt.wren  = head_q.valid && head_q.wren && (head_q.waddr != '0);
    out_pkt.waddr = head_q.valid ? head_q.waddr : '0;
    out_pkt.wdata = head_q.valid ? head_q.wdata : '0;
  end

  assign out_valid = out_pkt.valid;
  assign out_wren  = out_pkt.wren;
  assign out_waddr = out_pkt.waddr;
  assign out_wdata = out_pkt.wdata;

  ex_wb_fwd u_fwd_rs1 (
    .head  (head_q),
    .skid  (skid_q),
    .raddr (fwd_raddr1),
    .hit   (fwd_hit1),
    .data  (fwd_data1)
  );

  ex_wb_fwd u_fwd_rs2 (
    .head  (head_q),
    .skid  (skid_q),
    .raddr (fwd_raddr2),
    .hit   (fwd_hit2),
    .data  (fwd_data2)
  );

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Directed vector table plus a random FIFO-scoreboard phase for ex_wb_buffer.
module tb_ex_wb_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wren = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_wren;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic [4:0]  fwd_raddr1 = '0;
  logic [4:0]  fwd_raddr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  int total = 0;
  int bad   = 0;

  ex_wb_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wren    (in_wren),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wren   (out_wren),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata),
    .fwd_raddr1 (fwd_raddr1),
    .fwd_raddr2 (fwd_raddr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
  );

  always #5 clock = ~clock;

  // Inputs applied before an edge, expected outputs observed just after it.
  typedef struct {
    logic [31:0] rst_n, flush, in_valid, wren, waddr, wdata, out_ready, raddr1, raddr2;
    logic [31:0] e_in_ready, e_out_valid, e_out_wren, e_out_waddr, e_out_wdata;
    logic [31:0] e_hit1, e_data1, e_hit2, e_data2;
  } vec_t;

  typedef struct {
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } sb_t;

  vec_t vecs[17];
  sb_t  sb[$];

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset      = v.rst_n[0];
    flush      = v.flush[0];
    in_valid   = v.in_valid[0];
    in_wren    = v.wren[0];
    in_waddr   = v.waddr[4:0];
    in_wdata   = v.wdata;
    out_ready  = v.out_ready[0];
    fwd_raddr1 = v.raddr1[4:0];
    fwd_raddr2 = v.raddr2[4:0];
  endtask

  initial begin
    //          rst fl iv wr ad data          or r1 r2  ir ov ow oa odata         h1 d1            h2 d2
    vecs[0]  = '{0, 0, 0, 0, 0, 0,            0, 0, 0,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[1]  = '{1, 0, 1, 1, 5, 'h12345678,   1, 5, 0,  1, 1, 1, 5, 'h12345678,   1, 'h12345678,   0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0,            1, 5, 0,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[3]  = '{1, 0, 1, 1, 3, 'hA,          0, 3, 3,  1, 1, 1, 3, 'hA,          1, 'hA,          1, 'hA};
    vecs[4]  = '{1, 0, 1, 1, 3, 'hB,          0, 3, 5,  0, 1, 1, 3, 'hA,          1, 'hB,          0, 0};
    vecs[5]  = '{1, 0, 1, 1, 3, 'hC,          1, 3, 0,  1, 1, 1, 3, 'hB,          1, 'hB,          0, 0};
    vecs[6]  = '{1, 0, 0, 0, 0, 0,            1, 3, 0,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[7]  = '{1, 0, 1, 1, 0, 'hFFFF,       0, 0, 0,  1, 1, 0, 0, 'hFFFF,       0, 0,            0, 0};
    vecs[8]  = '{1, 0, 1, 0, 7, 'h77,         0, 7, 0,  0, 1, 0, 0, 'hFFFF,       0, 0,            0, 0};
    vecs[9]  = '{1, 1, 1, 1, 9, 'h99,         0, 9, 0,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 0,            1, 9, 0,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[11] = '{1, 0, 1, 1, 4, 'h44,         1, 4, 0,  1, 1, 1, 4, 'h44,         1, 'h44,         0, 0};
    vecs[12] = '{1, 0, 1, 1, 6, 'h66,         1, 4, 6,  1, 1, 1, 6, 'h66,         0, 0,            1, 'h66};
    vecs[13] = '{1, 0, 1, 1, 4, 'h45,         0, 4, 6,  0, 1, 1, 6, 'h66,         1, 'h45,         1, 'h66};
    vecs[14] = '{1, 0, 1, 1, 6, 'h67,         0, 6, 4,  0, 1, 1, 6, 'h66,         1, 'h66,         1, 'h45};
    vecs[15] = '{0, 0, 1, 1, 8, 'h88,         0, 4, 6,  1, 0, 0, 0, 0,            0, 0,            0, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 0,            0, 4, 6,  1, 0, 0, 0, 0,            0, 0,            0, 0};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput("in_ready",  i, 32'(in_ready),  vecs[i].e_in_ready);
      checkOutput("out_valid", i, 32'(out_valid), vecs[i].e_out_valid);
      checkOutput("out_wren",  i, 32'(out_wren),  vecs[i].e_out_wren);
      checkOutput("out_waddr", i, 32'(out_waddr), vecs[i].e_out_waddr);
      checkOutput("out_wdata", i, out_wdata,      vecs[i].e_out_wdata);
      checkOutput("fwd_hit1",  i, 32'(fwd_hit1),  vecs[i].e_hit1);
      checkOutput("fwd_data1", i, fwd_data1,      vecs[i].e_data1);
      checkOutput("fwd_hit2",  i, 32'(fwd_hit2),  vecs[i].e_hit2);
      checkOutput("fwd_data2", i, fwd_data2,      vecs[i].e_data2);
    end

    // Random handshakes against an in-order queue model holding at most two entries.
    $display("[TB] random handshake phase");
    for (int c = 0; c < 10000; c++) begin
      logic can_accept;
      @(negedge clock);
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_wren   = ($urandom_range(0, 3) != 0);
      in_waddr  = 5'($urandom_range(0, 31));
      in_wdata  = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      can_accept = (sb.size() < 2);
      checkOutput("rnd_in_ready",  c, 32'(in_ready),  32'(can_accept));
      checkOutput("rnd_out_valid", c, 32'(out_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
        checkOutput("rnd_out_waddr", c, 32'(out_waddr), 32'(sb[0].waddr));
        checkOutput("rnd_out_wdata", c, out_wdata,      sb[0].wdata);
        checkOutput("rnd_out_wren",  c, 32'(out_wren),  32'(sb[0].wren && (sb[0].waddr != 5'd0)));
        if (out_ready) begin
          void'(sb.pop_front());
        end
      end
      if (in_valid && can_accept) begin
        sb.push_back('{wren: in_wren, waddr: in_waddr, wdata: in_wdata});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
